// File: rtl/n64_pkg.sv
// Shared definitions for the N64 console transmitter and controller receiver.
// State encoding, pulse-width timing in microseconds and standard command bytes.
package n64_pkg;

   typedef enum logic [2:0] {
      IDLE,
      BIT_LOW,
      BIT_HIGH,
      STOP_LOW,
      STOP_HIGH,
      DONE
   } tx_state_t;

   localparam int BIT_US       = 4;
   localparam int ONE_LOW_US   = 1;
   localparam int ZERO_LOW_US  = 3;
   localparam int STOP_LOW_US  = 1;
   localparam int STOP_HIGH_US = 2;

   localparam logic [7:0] CMD_INFO  = 8'h00;
   localparam logic [7:0] CMD_POLL  = 8'h01;
   localparam logic [7:0] CMD_READ  = 8'h02;
   localparam logic [7:0] CMD_WRITE = 8'h03;

   // Segment lengths are counted 0..us-1 in a 3-bit microsecond counter.
   function automatic logic [2:0] us_last(input int us);
      return 3'(us - 1);
   endfunction

endpackage

// File: rtl/n64_us_tick.sv
// Microsecond prescaler: counts 0..CLKS_PER_US-1 and pulses tick_o on the last count.
// clr_i holds the count at 0 so the first tick lands exactly CLKS_PER_US cycles after release.
module n64_us_tick #(
   parameter int CLKS_PER_US = 14
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLKS_PER_US);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_US - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         cnt_q <= '0;
      end else if (cnt_q == LAST) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/n64_cmd_tx.sv
// N64 console command transmitter: pulse-width encodes cmd_i MSB first, then a console stop bit.
// Outputs are registered; the frame is (4*NUM_BITS+3) us of busy followed by a one-cycle done_o.
module n64_cmd_tx
   import n64_pkg::*;
#(
   parameter int CLKS_PER_US = 14,
   parameter int NUM_BITS    = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                start_i,
   input  logic [NUM_BITS-1:0] cmd_i,
   output logic                busy_o,
   output logic                done_o,
   output logic                n64_low_o
);

   localparam int BW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

   tx_state_t           state_q;
   logic [NUM_BITS-1:0] sr_q;
   logic [BW-1:0]       idx_q;
   logic [2:0]          us_q;
   logic                low_q;
   logic                busy_q;
   logic                done_q;
   logic                tick;
   logic [2:0]          low_last;

   // Prescaler is held in IDLE so it restarts in phase with every accepted start.
   n64_us_tick #(
      .CLKS_PER_US (CLKS_PER_US)
   ) u_tick (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .clr_i  (state_q == IDLE),
      .tick_o (tick)
   );

   assign low_last = sr_q[NUM_BITS-1] ? us_last(ONE_LOW_US) : us_last(ZERO_LOW_US);

   // us_q runs across the whole 4 us data bit; the low phase only decides where the edge falls.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         sr_q    <= '0;
         idx_q   <= '0;
         us_q    <= '0;
         low_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  sr_q    <= cmd_i;
                  idx_q   <= BW'(NUM_BITS - 1);
                  us_q    <= '0;
                  low_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  state_q <= BIT_LOW;
               end
            end
            BIT_LOW: begin
               if (tick) begin
                  us_q <= us_q + 3'd1;
                  if (us_q == low_last) begin
                     low_q   <= 1'b0;
                     state_q <= BIT_HIGH;
                  end
               end
            end
            BIT_HIGH: begin
               if (tick) begin
                  if (us_q == us_last(BIT_US)) begin
                     us_q  <= '0;
                     low_q <= 1'b1;
                     if (idx_q == '0) begin
                        state_q <= STOP_LOW;
                     end else begin
                        idx_q   <= idx_q - 1'b1;
                        sr_q    <= sr_q << 1;
                        state_q <= BIT_LOW;
                     end
                  end else begin
                     us_q <= us_q + 3'd1;
                  end
               end
            end
            STOP_LOW: begin
               if (tick) begin
                  if (us_q == us_last(STOP_LOW_US)) begin
                     us_q    <= '0;
                     low_q   <= 1'b0;
                     state_q <= STOP_HIGH;
                  end else begin
                     us_q <= us_q + 3'd1;
                  end
               end
            end
            STOP_HIGH: begin
               if (tick) begin
                  if (us_q == us_last(STOP_HIGH_US)) begin
                     us_q    <= '0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end else begin
                     us_q <= us_q + 3'd1;
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               low_q   <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign n64_low_o = low_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_n64_cmd_tx.sv
// Directed bench for n64_cmd_tx: measures low/high run lengths per bit against the command bits.
module tb_n64_cmd_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start1 = 1'b0;
   logic       start2 = 1'b0;
   logic [7:0] cmd = 8'h00;
   logic       sel = 1'b0;

   logic low1, busy1, done1;
   logic low2, busy2, done2;
   logic obs_low, obs_busy, obs_done;

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 clk = ~clk;

   n64_cmd_tx u_dut (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start1),
      .cmd_i     (cmd),
      .busy_o    (busy1),
      .done_o    (done1),
      .n64_low_o (low1)
   );

   n64_cmd_tx #(
      .CLKS_PER_US (2),
      .NUM_BITS    (8)
   ) u_dut2 (
      .clk_i     (clk),
      .rst_i     (rst),
      .start_i   (start2),
      .cmd_i     (cmd),
      .busy_o    (busy2),
      .done_o    (done2),
      .n64_low_o (low2)
   );

   assign obs_low  = sel ? low2  : low1;
   assign obs_busy = sel ? busy2 : busy1;
   assign obs_done = sel ? done2 : done1;

   task automatic chk(input string tag, input int obs, input int exp);
      total_cnt++;
      assert (obs === exp) else begin
         bad_cnt++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Entered in the first busy cycle; returns in the DONE cycle.
   task automatic measure_frame(input logic [7:0] c, input int cpu, input bit do_mid,
                                input logic [7:0] mid_cmd, input string tag);
      int run;
      int sum;
      int exp_lo;
      sum = 0;
      for (int i = 7; i >= 0; i--) begin
         exp_lo = c[i] ? cpu : 3 * cpu;
         run = 0;
         while (obs_low === 1'b1 && run < 400) begin run++; step(); end
         chk($sformatf("%s b%0d low", tag, i), run, exp_lo);
         sum += run;
         if (do_mid && i == 7) cmd = mid_cmd;
         run = 0;
         while (obs_low === 1'b0 && obs_busy === 1'b1 && run < 400) begin run++; step(); end
         chk($sformatf("%s b%0d high", tag, i), run, 4 * cpu - exp_lo);
         sum += run;
      end
      run = 0;
      while (obs_low === 1'b1 && run < 400) begin run++; step(); end
      chk({tag, " stop low"}, run, cpu);
      sum += run;
      run = 0;
      while (obs_low === 1'b0 && obs_busy === 1'b1 && run < 400) begin run++; step(); end
      chk({tag, " stop high"}, run, 2 * cpu);
      sum += run;
      chk({tag, " busy total"}, sum, 35 * cpu);
      chk({tag, " done pulse"}, int'(obs_done), 1);
      chk({tag, " done busy"}, int'(obs_busy), 0);
      chk({tag, " done line"}, int'(obs_low), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired total=%0d bad=%0d", total_cnt, bad_cnt);
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset and idle
      repeat (3) step();
      rst = 1'b0;
      step();
      chk("reset state", int'({low1, busy1, done1}), 0);
      for (int k = 0; k < 100; k++) begin
         chk("idle", int'({low1, busy1, done1, low2, busy2, done2}), 0);
         step();
      end

      // 2: POLL frame
      cmd = 8'h01; start1 = 1'b1;
      step();
      start1 = 1'b0;
      chk("poll first busy", int'(busy1), 1);
      measure_frame(8'h01, 14, 1'b0, 8'h00, "poll");
      step();
      chk("poll done one cycle", int'(done1), 0);

      // 3: all ones, then all zeros
      cmd = 8'hFF; start1 = 1'b1;
      step();
      start1 = 1'b0;
      measure_frame(8'hFF, 14, 1'b0, 8'h00, "ff");
      step();
      cmd = 8'h00; start1 = 1'b1;
      step();
      start1 = 1'b0;
      measure_frame(8'h00, 14, 1'b0, 8'h00, "00");
      step();

      // 4: start held high, cmd changed mid-frame
      cmd = 8'h01; start1 = 1'b1;
      step();
      measure_frame(8'h01, 14, 1'b1, 8'hFF, "held");
      step();
      chk("gap idle busy", int'(busy1), 0);
      chk("gap idle line", int'(low1), 0);
      step();
      start1 = 1'b0;
      chk("rearm busy", int'(busy1), 1);
      measure_frame(8'hFF, 14, 1'b0, 8'h00, "held2");
      step();

      // 5: reset at cycle 200 of a frame
      cmd = 8'h01; start1 = 1'b1;
      step();
      start1 = 1'b0;
      repeat (199) step();
      chk("pre-reset line", int'(low1), 1);
      chk("pre-reset busy", int'(busy1), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("post-reset", int'({low1, busy1, done1}), 0);
      for (int k = 202; k <= 210; k++) begin
         step();
         chk("post-reset quiet", int'({low1, busy1, done1}), 0);
      end
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      measure_frame(8'h01, 14, 1'b0, 8'h00, "after-reset");
      step();

      // 6: CLKS_PER_US=2 instance
      sel = 1'b1;
      cmd = 8'h80; start2 = 1'b1;
      step();
      start2 = 1'b0;
      measure_frame(8'h80, 2, 1'b0, 8'h00, "fast");
      step();
      chk("fast done one cycle", int'(done2), 0);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/n64_cmd_tx.md
Name: n64_cmd_tx

Overview:
Console-side transmitter for the N64 single-wire controller protocol. It serialises a command byte (normally POLL = 0x01) onto the open-drain data line using N64 pulse-width bit encoding, then sends a console stop bit. It is the initiating end of the link: the controller's reply is captured by the existing N64 receiver. It runs from the 14 MHz internal oscillator domain.

Parameters:
CLKS_PER_US, 14, clk_i cycles per microsecond (14.00 MHz OSCH); must be >= 2
NUM_BITS, 8, command length in bits, sent MSB first

Ports:
clk_i  input  1  system clock, 14 MHz
rst_i  input  1  synchronous reset, active-high
start_i  input  1  request to transmit cmd_i; sampled only in IDLE
cmd_i  input  NUM_BITS  command word; latched when start is accepted
busy_o  output  1  high while a frame is on the wire
done_o  output  1  one-cycle pulse after the stop bit completes
n64_low_o  output  1  1 = pull the data line low; 0 = release it (pull-up gives high)

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- Reset values: n64_low_o=0 (line released), busy_o=0, done_o=0, state=IDLE, all counters=0.
- States: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, STOP_HIGH, DONE.
- IDLE: if start_i=1 at edge t, latch cmd_i into a shift register, set bit index = NUM_BITS-1, go to BIT_LOW. n64_low_o and busy_o go high from cycle t+1.
- Timing base: a microsecond tick from a prescaler counting 0..CLKS_PER_US-1. The prescaler restarts at 0 on start acceptance, so every segment is an exact multiple of CLKS_PER_US cycles.
- Data bit, 4 us total:
  - Bit value 1: 1 us low, then 3 us high.
  - Bit value 0: 3 us low, then 1 us high.
  - BIT_LOW moves to BIT_HIGH when its low time expires.
  - BIT_HIGH then goes to BIT_LOW for the next bit (shift left), or to STOP_LOW after the bit with index 0.
- Stop bit: STOP_LOW drives low for 1 us. STOP_HIGH releases the line for 2 us, then goes to DONE.
- DONE: lasts exactly one cycle. done_o=1, busy_o=0, n64_low_o=0, then returns to IDLE.
- Frame length: (4*NUM_BITS + 3) us of busy. The default is 35 us = 490 cycles.
- start_i is ignored outside IDLE, including in the DONE cycle. cmd_i changes during a frame have no effect.
- Back-to-back frames: the earliest accepted start is the cycle after DONE. There is a minimum 1-cycle gap between frames, and the line stays released during it.
- Reset mid-frame: the line is released on the next edge and the state returns to IDLE. No done_o pulse is produced and the partial frame is abandoned.
- Line is never driven high. n64_low_o=0 in every state except BIT_LOW and STOP_LOW.
- All outputs are registered (no combinational path from inputs to outputs).

Decomposition:
- Package n64_pkg holds:
  - state enum (tx_state_t)
  - timing constants BIT_US=4, ONE_LOW_US=1, ZERO_LOW_US=3, STOP_LOW_US=1, STOP_HIGH_US=2
  - command constants CMD_INFO=8'h00, CMD_POLL=8'h01, CMD_READ=8'h02, CMD_WRITE=8'h03
- The package is shared with the receiver.
- One sub-module: n64_us_tick. It contains the prescaler (CLKS_PER_US parameter) with clear input and 1-cycle tick_o, and is reusable by the receiver's sampler.

Test Plan:
1. Reset then idle 100 cycles, start_i=0 -> n64_low_o=0, busy_o=0, done_o=0 throughout.
2. start_i pulse at cycle 0 with cmd_i=8'h01 ->
   - Seven 0-bits, each 42 cycles low then 14 high.
   - One 1-bit: 14 low, 42 high.
   - Stop: 14 low, 28 high.
   - busy_o high cycles 1..490; done_o=1 exactly at cycle 491.
3. cmd_i=8'hFF, then cmd_i=8'h00 -> every bit low 14/high 42, then every bit low 42/high 14. Total busy is 490 cycles in both cases.
4. start_i held high continuously with cmd_i=8'h01 -> frames repeat with exactly one released idle cycle (the DONE cycle) plus one IDLE accept cycle between busy periods. cmd_i changed mid-frame to 8'hFF does not alter the current frame.
5. rst_i asserted at cycle 200 of a frame -> n64_low_o=0 and busy_o=0 from cycle 201, no done_o pulse. A new start at cycle 210 produces a full correct 490-cycle frame.
6. Parameter sweep: CLKS_PER_US=2, NUM_BITS=8, cmd_i=8'h80 -> first bit low 2 cycles / high 6, remaining bits low 6 / high 2, stop low 2 / high 4. Total busy 70 cycles.
